// File: rtl/alex_spi_ctrl.sv
// Alex filter-board SPI sequencer: serialises {tx_relay, atten, lpf, hpf, 8'h00}
// MSB first on change of any input, after reset, and on a periodic refresh.
module alex_spi_ctrl #(
    parameter int unsigned CLK_DIV = 4,
    parameter logic [23:0] REFRESH = 24'd1_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] hpf,
    input  logic [6:0] lpf,
    input  logic [1:0] atten,
    input  logic       tx_relay,
    output logic       spi_clk,
    output logic       spi_data,
    output logic       spi_load,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_HIGH  = 3'd2;
    localparam logic [2:0] ST_LATCH = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [4:0] BIT_LAST = 5'd23;

    logic [2:0]  state_reg, state_next;
    logic [7:0]  div_cnt_reg, div_cnt_next;
    logic [4:0]  bit_cnt_reg, bit_cnt_next;
    logic [23:0] shreg_reg, shreg_next;
    logic [15:0] last_sent_reg, last_sent_next;
    logic        pending_reg, pending_next;
    logic [23:0] refresh_cnt_reg, refresh_cnt_next;

    logic        spi_clk_reg, spi_clk_next;
    logic        spi_data_reg, spi_data_next;
    logic        spi_load_reg, spi_load_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;

    logic [15:0] packed_cfg;
    logic        div_last;
    logic        refresh_hit;
    logic [23:0] refresh_inc;
    logic        trigger;

    assign packed_cfg = {tx_relay, atten, lpf, hpf};
    assign div_last   = (div_cnt_reg == DIV_LAST);

    // With refresh disabled the counter just saturates so it can never wrap into a hit.
    generate
        if (REFRESH != 24'd0) begin : g_refresh_on
            assign refresh_hit = (refresh_cnt_reg == (REFRESH - 24'd1));
            assign refresh_inc = refresh_cnt_reg + 24'd1;
        end else begin : g_refresh_off
            assign refresh_hit = 1'b0;
            assign refresh_inc = (&refresh_cnt_reg) ? refresh_cnt_reg
                                                    : refresh_cnt_reg + 24'd1;
        end
    endgenerate

    assign trigger = pending_reg | (packed_cfg != last_sent_reg) | refresh_hit;

    always_comb begin
        state_next       = state_reg;
        div_cnt_next     = div_cnt_reg;
        bit_cnt_next     = bit_cnt_reg;
        shreg_next       = shreg_reg;
        last_sent_next   = last_sent_reg;
        pending_next     = pending_reg;
        refresh_cnt_next = refresh_cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                if (trigger) begin
                    state_next       = ST_SETUP;
                    div_cnt_next     = 8'd0;
                    bit_cnt_next     = 5'd0;
                    shreg_next       = {packed_cfg, 8'h00};
                    last_sent_next   = packed_cfg;
                    pending_next     = 1'b0;
                    refresh_cnt_next = 24'd0;
                end else begin
                    refresh_cnt_next = refresh_inc;
                end
            end
            ST_SETUP: begin
                if (div_last) begin
                    state_next   = ST_HIGH;
                    div_cnt_next = 8'd0;
                end else begin
                    div_cnt_next = div_cnt_reg + 8'd1;
                end
            end
            ST_HIGH: begin
                if (div_last) begin
                    div_cnt_next = 8'd0;
                    shreg_next   = {shreg_reg[22:0], 1'b0};
                    bit_cnt_next = bit_cnt_reg + 5'd1;
                    state_next   = (bit_cnt_reg == BIT_LAST) ? ST_LATCH : ST_SETUP;
                end else begin
                    div_cnt_next = div_cnt_reg + 8'd1;
                end
            end
            ST_LATCH: begin
                if (div_last) begin
                    state_next   = ST_GAP;
                    div_cnt_next = 8'd0;
                end else begin
                    div_cnt_next = div_cnt_reg + 8'd1;
                end
            end
            ST_GAP: begin
                if (div_last) begin
                    state_next   = ST_IDLE;
                    div_cnt_next = 8'd0;
                end else begin
                    div_cnt_next = div_cnt_reg + 8'd1;
                end
            end
            default: begin
                state_next   = ST_IDLE;
                div_cnt_next = 8'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the pins themselves are flops.
    always_comb begin
        spi_clk_next  = (state_next == ST_HIGH);
        spi_data_next = ((state_next == ST_SETUP) || (state_next == ST_HIGH)) && shreg_next[23];
        spi_load_next = (state_next == ST_LATCH);
        busy_next     = (state_next != ST_IDLE);
        done_next     = (state_next == ST_GAP) && (div_cnt_next == DIV_LAST);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            div_cnt_reg     <= 8'd0;
            bit_cnt_reg     <= 5'd0;
            shreg_reg       <= 24'd0;
            last_sent_reg   <= 16'd0;
            pending_reg     <= 1'b1;
            refresh_cnt_reg <= 24'd0;
            spi_clk_reg     <= 1'b0;
            spi_data_reg    <= 1'b0;
            spi_load_reg    <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            div_cnt_reg     <= div_cnt_next;
            bit_cnt_reg     <= bit_cnt_next;
            shreg_reg       <= shreg_next;
            last_sent_reg   <= last_sent_next;
            pending_reg     <= pending_next;
            refresh_cnt_reg <= refresh_cnt_next;
            spi_clk_reg     <= spi_clk_next;
            spi_data_reg    <= spi_data_next;
            spi_load_reg    <= spi_load_next;
            busy_reg        <= busy_next;
            done_reg        <= done_next;
        end
    end

    assign spi_clk  = spi_clk_reg;
    assign spi_data = spi_data_reg;
    assign spi_load = spi_load_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule
